// File: rtl/sort_bitonic_pipe.sv
// rtl/sort_bitonic_pipe.sv - pipelined bitonic sorting network with valid/ready flow control
//
// Purpose:
//   Sorts a vector of N elements of W bits with a bitonic network of
//   S = L*(L+1)/2 compare-exchange columns (L = log2(N)). There is one
//   register stage per column. Each vector carries its own direction bit
//   and a pass-through tag. The whole pipe freezes when the output is
//   valid but not accepted.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      input vector valid
//   in_ready   out  1      input accepted this cycle (= no stall)
//   in_data    in   N*W    element i at in_data[i*W +: W]
//   in_desc    in   1      1 = descending, 0 = ascending
//   in_tag     in   TAG_W  sideband returned with the result
//   out_valid  out  1      sorted vector valid
//   out_ready  in   1      downstream accepts
//   out_data   out  N*W    sorted elements, same packing as in_data
//   out_desc   out  1      direction used for this vector
//   out_tag    out  TAG_W  tag of this vector

module sort_bitonic_pipe #(
  parameter int N      = 16,
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_data,
  input  logic               in_desc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*W-1:0]     out_data,
  output logic               out_desc,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int L = $clog2(N);
  localparam int S = L * (L + 1) / 2;

  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $fatal(1, "sort_bitonic_pipe: N must be a power of two and at least 2");
  end

  if (TAG_W < 1) begin : g_bad_tag
    $fatal(1, "sort_bitonic_pipe: TAG_W must be at least 1");
  end

  // a > b under the configured number interpretation; equal never swaps.
  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED) begin
      gt = $signed(a) > $signed(b);
    end else begin
      gt = a > b;
    end
  endfunction

  // Stage registers, index c holds the result of compare column c.
  logic               valid_q [S];
  logic [N*W-1:0]     data_q  [S];
  logic               desc_q  [S];
  logic [TAG_W-1:0]   tag_q   [S];

  // Column inputs (previous stage or the input port) and column results.
  logic               src_valid [S];
  logic [N*W-1:0]     src_data  [S];
  logic               src_desc  [S];
  logic [TAG_W-1:0]   src_tag   [S];
  logic [N*W-1:0]     data_d    [S];

  logic stall;

  // Stall depends only on the output side, so in_ready never looks at in_valid.
  assign stall    = valid_q[S-1] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_desc[0]  = in_desc;
    src_tag[0]   = in_tag;
    for (int c = 1; c < S; c++) begin
      src_valid[c] = valid_q[c-1];
      src_data[c]  = data_q[c-1];
      src_desc[c]  = desc_q[c-1];
      src_tag[c]   = tag_q[c-1];
    end
  end

  // Column C of phase p, sub-step q: block size K = 2^p, partner distance J = 2^(q-1).
  // A pair sits in an ascending block when (i & K) == 0; the vector's desc bit
  // inverts every comparator, which mirrors the final order.
  for (genvar p = 1; p <= L; p++) begin : g_phase
    for (genvar q = p; q >= 1; q--) begin : g_col
      localparam int C = p * (p - 1) / 2 + (p - q);
      localparam int K = 1 << p;
      localparam int J = 1 << (q - 1);

      logic [N*W-1:0] res;
      logic [W-1:0]   lo;
      logic [W-1:0]   hi;
      logic           up;

      always_comb begin
        res = src_data[C];
        lo  = '0;
        hi  = '0;
        up  = 1'b0;
        for (int i = 0; i < N; i++) begin
          if ((i ^ J) > i) begin
            lo = src_data[C][i*W +: W];
            hi = src_data[C][(i ^ J)*W +: W];
            up = (((i & K) == 0) != src_desc[C]);
            if (up ? gt(lo, hi) : gt(hi, lo)) begin
              res[i*W +: W]       = hi;
              res[(i ^ J)*W +: W] = lo;
            end
          end
        end
      end

      assign data_d[C] = res;
    end
  end

  // Bubbles clear their payload so the output reads zero whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < S; c++) begin
        valid_q[c] <= 1'b0;
        data_q[c]  <= '0;
        desc_q[c]  <= 1'b0;
        tag_q[c]   <= '0;
      end
    end else if (!stall) begin
      for (int c = 0; c < S; c++) begin
        valid_q[c] <= src_valid[c];
        if (src_valid[c]) begin
          data_q[c] <= data_d[c];
          desc_q[c] <= src_desc[c];
          tag_q[c]  <= src_tag[c];
        end else begin
          data_q[c] <= '0;
          desc_q[c] <= 1'b0;
          tag_q[c]  <= '0;
        end
      end
    end
  end

  assign out_valid = valid_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_desc  = desc_q[S-1];
  assign out_tag   = tag_q[S-1];

endmodule

// File: tb/tb_sort_bitonic_pipe.sv
// tb/tb_sort_bitonic_pipe.sv - directed and streaming checks of sort_bitonic_pipe
module tb_sort_bitonic_pipe;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int S  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance, N=16 W=16 unsigned
  logic            in_valid, in_ready, in_desc;
  logic [N*W-1:0]  in_data;
  logic [TW-1:0]   in_tag;
  logic            out_valid, out_ready, out_desc;
  logic [N*W-1:0]  out_data;
  logic [TW-1:0]   out_tag;

  // N=4 W=8 signed and unsigned pair sharing inputs
  logic        f_valid, f_desc, f_oready;
  logic [31:0] f_data;
  logic [0:0]  f_tag;
  logic        fs_iready, fs_ovalid, fs_odesc, fu_iready, fu_ovalid, fu_odesc;
  logic [31:0] fs_odata, fu_odata;
  logic [0:0]  fs_otag, fu_otag;

  // N=2 W=8
  logic        t_valid, t_desc, t_oready, t_iready, t_ovalid, t_odesc;
  logic [15:0] t_data, t_odata;
  logic [0:0]  t_tag, t_otag;

  // N=64 W=8
  logic         b_valid, b_desc, b_oready, b_iready, b_ovalid, b_odesc;
  logic [511:0] b_data, b_odata;
  logic [0:0]   b_tag, b_otag;

  sort_bitonic_pipe #(.N(N), .W(W), .SIGNED(1'b0), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_desc(in_desc), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_desc(out_desc), .out_tag(out_tag));

  sort_bitonic_pipe #(.N(4), .W(8), .SIGNED(1'b1), .TAG_W(1)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(f_valid), .in_ready(fs_iready), .in_data(f_data),
    .in_desc(f_desc), .in_tag(f_tag), .out_valid(fs_ovalid), .out_ready(f_oready),
    .out_data(fs_odata), .out_desc(fs_odesc), .out_tag(fs_otag));

  sort_bitonic_pipe #(.N(4), .W(8), .SIGNED(1'b0), .TAG_W(1)) u_u4 (
    .clk(clk), .rst(rst), .in_valid(f_valid), .in_ready(fu_iready), .in_data(f_data),
    .in_desc(f_desc), .in_tag(f_tag), .out_valid(fu_ovalid), .out_ready(f_oready),
    .out_data(fu_odata), .out_desc(fu_odesc), .out_tag(fu_otag));

  sort_bitonic_pipe #(.N(2), .W(8), .SIGNED(1'b0), .TAG_W(1)) u_n2 (
    .clk(clk), .rst(rst), .in_valid(t_valid), .in_ready(t_iready), .in_data(t_data),
    .in_desc(t_desc), .in_tag(t_tag), .out_valid(t_ovalid), .out_ready(t_oready),
    .out_data(t_odata), .out_desc(t_odesc), .out_tag(t_otag));

  sort_bitonic_pipe #(.N(64), .W(8), .SIGNED(1'b0), .TAG_W(1)) u_n64 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_iready), .in_data(b_data),
    .in_desc(b_desc), .in_tag(b_tag), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_data(b_odata), .out_desc(b_odesc), .out_tag(b_otag));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain bubble sort on sign-aware keys, reversed for descending.
  function automatic logic [511:0] ref_sort(input logic [511:0] v, input int n, input int w,
                                            input bit sgn, input bit dsc);
    longint       k [64];
    longint       t;
    logic [511:0] mask, tmp, r;
    mask = (512'd1 << w) - 512'd1;
    for (int i = 0; i < n; i++) begin
      tmp  = (v >> (i * w)) & mask;
      k[i] = longint'(tmp[63:0]);
      if (sgn && tmp[w-1]) k[i] = k[i] - (longint'(1) << w);
    end
    for (int a = 0; a < n - 1; a++)
      for (int b = 0; b < n - 1 - a; b++)
        if (k[b] > k[b+1]) begin
          t = k[b]; k[b] = k[b+1]; k[b+1] = t;
        end
    r = '0;
    for (int i = 0; i < n; i++) begin
      tmp = 512'(k[dsc ? (n - 1 - i) : i]) & mask;
      r   = r | (tmp << (i * w));
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_vec(input int c);
    logic [N*W-1:0] v;
    for (int e = 0; e < N; e++)
      v[e*W +: W] = 16'($urandom_range(0, (c % 3 == 0) ? 15 : 65535));
    return v;
  endfunction

  // Scoreboard for the main instance.
  typedef struct {
    logic [N*W-1:0] d;
    logic           desc;
    logic [TW-1:0]  tag;
  } exp_t;
  exp_t exp_q[$];
  int   n_out = 0;
  logic prev_stall = 1'b0;
  logic [N*W-1:0] prev_data = '0;

  always @(negedge clk) begin
    exp_t         e;
    logic [511:0] r;
    if (!rst) begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (!out_valid) check("bubble_zero", out_data, '0);
      if (prev_stall) check("hold_data", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_desc", out_desc, e.desc);
          check("out_tag", out_tag, e.tag);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        r      = ref_sort(512'(in_data), N, W, 1'b0, in_desc);
        e.d    = r[N*W-1:0];
        e.desc = in_desc;
        e.tag  = in_tag;
        exp_q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_main(input logic [N*W-1:0] d, input logic dsc, input logic [TW-1:0] tg);
    in_data  = d;
    in_desc  = dsc;
    in_tag   = tg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_main(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int             lat, base, vcnt, sent, stall_cnt;
  logic [N*W-1:0] vec, expv;
  int             dup_in  [16] = '{7, 7, 3, 3, 9, 9, 0, 0, 15, 15, 1, 1, 7, 3, 0, 15};
  int             dup_exp [16] = '{0, 0, 0, 1, 1, 3, 3, 3, 7, 7, 7, 9, 9, 15, 15, 15};
  logic [511:0]   bv [3];
  logic [511:0]   be [3];
  logic [31:0]    f_exp_s [2] = '{32'h7F00FF80, 32'h80FF007F};
  logic [31:0]    f_exp_u [2] = '{32'hFF807F00, 32'h007F80FF};

  initial begin
    rst = 1'b1;
    in_valid = 1'b1; in_data = '1; in_desc = 1'b0; in_tag = 4'hF; out_ready = 1'b1;
    f_valid = 1'b0; f_desc = 1'b0; f_data = '0; f_tag = '0; f_oready = 1'b1;
    t_valid = 1'b0; t_desc = 1'b0; t_data = '0; t_tag = '0; t_oready = 1'b1;
    b_valid = 1'b0; b_desc = 1'b0; b_data = '0; b_tag = '0; b_oready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0;

    // reset state; the vector offered during reset must never appear
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_desc", out_desc, 1'b0);
    check("rst_out_tag", out_tag, '0);
    check("rst_in_ready", in_ready, 1'b1);
    vcnt = 0;
    repeat (S + 2) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    check("rst_in_ignored", vcnt, 0);

    // reversed ramp, ascending, tag 5, latency S, one-cycle valid
    for (int i = 0; i < N; i++) begin
      vec[i*W +: W]  = 16'(15 - i);
      expv[i*W +: W] = 16'(i);
    end
    send_main(vec, 1'b0, 4'd5);
    wait_main(lat);
    check("asc_latency", lat, S);
    check("asc_data", out_data, expv);
    check("asc_tag", out_tag, 4'd5);
    @(posedge clk); #1;
    check("asc_one_cycle", out_valid, 1'b0);

    // same ramp descending: already in descending order
    send_main(vec, 1'b1, 4'd9);
    wait_main(lat);
    check("desc_latency", lat, S);
    check("desc_data", out_data, vec);
    check("desc_flag", out_desc, 1'b1);
    check("desc_tag", out_tag, 4'd9);
    @(posedge clk); #1;

    // duplicates, ascending
    for (int i = 0; i < N; i++) begin
      vec[i*W +: W]  = 16'(dup_in[i]);
      expv[i*W +: W] = 16'(dup_exp[i]);
    end
    send_main(vec, 1'b0, 4'd3);
    wait_main(lat);
    check("dup_latency", lat, S);
    check("dup_data", out_data, expv);
    @(posedge clk); #1;

    // 1000 back-to-back random vectors with mixed directions
    base = n_out;
    vcnt = 0;
    for (int c = 0; c < 1000; c++) begin
      if (c >= S && out_valid) vcnt++;
      in_valid = 1'b1;
      in_data  = rand_vec(c);
      in_desc  = 1'($urandom_range(0, 1));
      in_tag   = 4'(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    check("rand_count", n_out - base, 1000);
    check("rand_per_cycle", vcnt, 1000 - S);
    check("rand_drained", exp_q.size(), 0);

    // backpressure: 20 vectors, out_ready low for cycles 12..17
    base = n_out;
    sent = 0;
    stall_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      out_ready = !(k >= 12 && k <= 17);
      if (sent < 20) begin
        in_valid = 1'b1;
        for (int e = 0; e < N; e++)
          in_data[e*W +: W] = 16'((sent * 7919 + e * 104729) ^ (e << 3));
        in_desc = sent[0];
        in_tag  = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (out_valid && !out_ready) stall_cnt++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", sent, 20);
    check("bp_received", n_out - base, 20);
    check("bp_stall_cycles", stall_cnt, 6);
    check("bp_drained", exp_q.size(), 0);

    // reset with 6 vectors in flight
    for (int k = 0; k < 6; k++) send_main(rand_vec(k + 1), 1'(k), 4'(k));
    rst = 1'b1; in_valid = 1'b1; in_data = '1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    exp_q.delete();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_ready", in_ready, 1'b1);
    vcnt = 0;
    repeat (S + 2) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    check("mid_rst_flushed", vcnt, 0);
    for (int i = 0; i < N; i++) vec[i*W +: W] = 16'(15 - i);
    send_main(vec, 1'b0, 4'd7);
    wait_main(lat);
    check("post_rst_latency", lat, S);
    check("post_rst_tag", out_tag, 4'd7);
    @(posedge clk); #1;
    check("post_rst_alone", out_valid, 1'b0);

    // N=4 W=8: signed vs unsigned, both directions
    for (int d = 0; d < 2; d++) begin
      f_data = 32'hFF007F80; f_desc = 1'(d); f_valid = 1'b1;
      @(posedge clk); #1;
      f_valid = 1'b0; f_data = '0;
      @(posedge clk); #1;
      check("s4_early", fs_ovalid, 1'b0);
      @(posedge clk); #1;
      check("s4_valid", fs_ovalid, 1'b1);
      check("s4_data", fs_odata, f_exp_s[d]);
      check("u4_valid", fu_ovalid, 1'b1);
      check("u4_data", fu_odata, f_exp_u[d]);
      @(posedge clk); #1;
    end

    // N=2: one registered comparator
    t_data = 16'h0305; t_desc = 1'b0; t_valid = 1'b1;
    @(posedge clk); #1;
    check("n2_valid", t_ovalid, 1'b1);
    check("n2_swap", t_odata, 16'h0503);
    t_data = 16'h0305; t_desc = 1'b1;
    @(posedge clk); #1;
    check("n2_desc", t_odata, 16'h0305);
    t_data = 16'h0404; t_desc = 1'b0;
    @(posedge clk); #1;
    check("n2_equal", t_odata, 16'h0404);
    t_valid = 1'b0;
    @(posedge clk); #1;
    check("n2_bubble", t_odata, 16'h0000);

    // N=64: three random vectors back-to-back, latency 21
    for (int v = 0; v < 3; v++) begin
      for (int e = 0; e < 64; e++) bv[v][e*8 +: 8] = 8'($urandom);
      be[v] = ref_sort(bv[v], 64, 8, 1'b0, v == 1);
    end
    for (int v = 0; v < 3; v++) begin
      b_data = bv[v]; b_desc = (v == 1); b_valid = 1'b1;
      @(posedge clk); #1;
    end
    b_valid = 1'b0; b_data = '0;
    repeat (17) @(posedge clk);
    #1;
    check("n64_early", b_ovalid, 1'b0);
    for (int v = 0; v < 3; v++) begin
      @(posedge clk); #1;
      check("n64_valid", b_ovalid, 1'b1);
      check("n64_data", b_odata, be[v]);
    end
    @(posedge clk); #1;
    check("n64_end", b_ovalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_bitonic_pipe.md
Name: sort_bitonic_pipe

Overview:
- Parametrised, fully pipelined bitonic sorting network that sorts N elements of W bits each.
- It has a valid/ready handshake on both sides, and sort direction is selected per vector.
- A pass-through tag travels with each vector.
- It replaces the fixed 16x16b combinational sorter in datapaths that need timing closure and flow control.

Parameters:
- N, 16: element count; power of two, 2..64.
- W, 16: element width in bits.
- SIGNED, 0: 1 = compare as two's complement, 0 = unsigned.
- TAG_W, 4: sideband tag width, minimum 1.
- Derived, not overridable: L = log2(N); S = L*(L+1)/2 (number of compare-exchange columns, 10 for N=16).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept an input vector this cycle.
- in_data  in  N*W  element i at in_data[i*W +: W].
- in_desc  in  1  1 = descending, 0 = ascending; sampled with in_data.
- in_tag  in  TAG_W  sideband; returned unchanged with the result.
- out_valid  out  1  sorted vector valid.
- out_ready  in  1  downstream accepts.
- out_data  out  N*W  sorted elements, same packing as in_data.
- out_desc  out  1  direction used for this vector.
- out_tag  out  TAG_W  tag of this vector.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Pipeline structure: S register stages, one per compare-exchange column of the standard bitonic network.
  - Each stage holds: valid bit, N*W data, desc bit, tag.
- Direction: ascending means out element 0 is the minimum and element N-1 the maximum. Descending is the mirror.
  - Direction is applied by flipping the sense of every comparator in that vector's path.
  - Mixed directions in flight are legal; each vector uses its own desc.
- Compare rule:
  - Unsigned or signed per SIGNED.
  - Equal elements are not swapped.
  - Sorting need not be stable, but the output is a permutation of the input multiset.
- Stall rule: stall = out_valid & ~out_ready.
  - When stall = 1, every stage holds its contents.
  - Otherwise every stage advances by one.
- Ready rule: in_ready = ~stall, combinational from out_valid and out_ready only, with no dependency on in_valid.
- Input transfer: occurs when in_valid & in_ready.
  - If in_valid = 0 while advancing, a bubble (valid = 0) enters stage 1.
- Latency: a vector accepted at cycle t appears at the outputs at cycle t+S, given no stall cycles. Each stall cycle adds one.
- Throughput: one vector per cycle sustained while out_ready = 1.
- Output stability: outputs are stage S registers. While out_valid = 1 and out_ready = 0, out_data, out_desc and out_tag are held stable.
- Bubble content: bubble data content is don't-care internally, but out_data reads 0 whenever out_valid = 0 (data registers are cleared when a bubble is loaded).
- Reset:
  - All valid bits go to 0; out_valid = 0, out_data = 0, out_desc = 0, out_tag = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight vectors; no partial output is produced.
  - in_valid during reset is ignored.
- Simultaneous events: output transfer and input transfer in the same cycle are legal and lose no data.
- Ordering: vectors leave in acceptance order.
- Degenerate size: N=2 gives S=1, a single registered comparator.
- Width limit: no arithmetic beyond the comparator; no width growth.
- Elaboration checks: N not a power of two, or N < 2, is a fatal elaboration error.

Test Plan:
- N=16, W=16, asc: in element i = 15-i (0x000F..0x0000), tag 5, out_ready=1 -> exactly 10 cycles later out element i = i, out_tag=5, out_valid high for 1 cycle.
- Same vector with in_desc=1, plus duplicates {7,7,3,3,...}, then random vectors back-to-back for 1000 cycles -> each output matches a reference sort in the requested direction; one output per cycle, order and tags preserved.
- SIGNED=1, W=8: inputs {0x80,0x7F,0x00,0xFF,...} ascending -> 0x80 (-128) first, 0x7F last; with SIGNED=0 -> 0x00 first, 0xFF last.
- Backpressure: stream 20 vectors, drop out_ready for cycles 12..17 -> in_ready low exactly while out_valid&~out_ready, out_data constant during hold, no loss or duplication, all 20 emerge in order.
- Reset mid-stream: assert rst with 6 vectors in flight -> next cycle out_valid=0, out_data=0, in_ready=1; the next accepted vector emerges alone after S cycles.
- N=2 and N=64 builds: the N=2 ascending swap {5,3} -> {3,5} with latency 1; the N=64 random vectors are sorted with latency 21.
